matrix_mem_responder: RTL and testbench

Memory-side responder for the matrix operation units' BRAM interface. It holds the element store and services one op unit's `mem_rd_en`/`mem_wr_en` requests with a registered one-cycle read. It also provides a region-clear engine for the controller, plus saturating access counters for debug display. It sits between the op-unit mux and the controller, in place of a bare BRAM.

---
 rtl/matrix_mem_responder.sv | 251 +++++++++++++++++++++++++
 tb/tb_matrix_mem_responder.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mem_responder.sv
// matrix_mem_responder: element store for the matrix op units with a
// registered write-first read port, a region-clear engine and debug counters.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_rd_en/addr/data      op-unit read request, registered read data
//   mem_wr_en/addr/data      op-unit write request
//   clr_start/base/len       region clear request (accepted only in idle)
//   busy, clr_done           clear in progress, one-cycle completion pulse
//   rd_count, wr_count       saturating serviced-request counters
//   err_drop                 sticky: op-unit request arrived during a clear
//   err_oob                  sticky: out-of-range access (range check only)
//
// Optional feature macro: MATRIX_MEM_RANGE_CHECK_EN
//   defined   -> addresses >= MEM_DEPTH flagged, writes dropped, reads give 0,
//                clear stops when its pointer reaches MEM_DEPTH
//   undefined -> addresses reduced modulo MEM_DEPTH, err_oob tied to 0

`ifndef ELEMENT_WIDTH
`define ELEMENT_WIDTH 16
`endif
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 12
`endif

module matrix_mem_responder #(
    parameter int ELEMENT_WIDTH = `ELEMENT_WIDTH,
    parameter int ADDR_WIDTH    = `BRAM_ADDR_WIDTH,
    parameter int MEM_DEPTH     = 2048
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_rd_en,
    input  logic [ADDR_WIDTH-1:0]    mem_rd_addr,
    output logic [ELEMENT_WIDTH-1:0] mem_rd_data,
    input  logic                     mem_wr_en,
    input  logic [ADDR_WIDTH-1:0]    mem_wr_addr,
    input  logic [ELEMENT_WIDTH-1:0] mem_wr_data,
    input  logic                     clr_start,
    input  logic [ADDR_WIDTH-1:0]    clr_base,
    input  logic [ADDR_WIDTH:0]      clr_len,
    output logic                     busy,
    output logic                     clr_done,
    output logic [15:0]              rd_count,
    output logic [15:0]              wr_count,
    output logic                     err_drop,
    output logic                     err_oob
);

    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DONE
    } state_t;

    logic [ELEMENT_WIDTH-1:0] mem [MEM_DEPTH];

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]      remain_q, remain_d;
    logic                     busy_q, busy_d;
    logic                     clr_done_q, clr_done_d;
    logic [ELEMENT_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [15:0]              rd_count_q, rd_count_d;
    logic [15:0]              wr_count_q, wr_count_d;
    logic                     err_drop_q, err_drop_d;
    logic                     err_oob_q, err_oob_d;

    logic                     mem_we;
    logic [ADDR_WIDTH-1:0]    mem_waddr;
    logic [ELEMENT_WIDTH-1:0] mem_wdata;

    logic [ADDR_WIDTH-1:0]    rd_idx, wr_idx;
    logic                     rd_ok, wr_ok;
    logic                     rd_srv, wr_srv, wr_do;

    function automatic logic [ADDR_WIDTH-1:0] wrap_addr(
        input logic [ADDR_WIDTH-1:0] a
    );
        logic [ADDR_WIDTH:0] r;
        r = {1'b0, a} % DEPTH;
        return r[ADDR_WIDTH-1:0];
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH;
    endfunction

`ifdef MATRIX_MEM_RANGE_CHECK_EN
    assign rd_idx = mem_rd_addr;
    assign wr_idx = mem_wr_addr;
    assign rd_ok  = in_range(mem_rd_addr);
    assign wr_ok  = in_range(mem_wr_addr);
`else
    assign rd_idx = wrap_addr(mem_rd_addr);
    assign wr_idx = wrap_addr(mem_wr_addr);
    assign rd_ok  = 1'b1;
    assign wr_ok  = 1'b1;
`endif

    // busy_q is high exactly while in S_CLEAR; op requests are dropped then
    assign rd_srv = mem_rd_en && !busy_q;
    assign wr_srv = mem_wr_en && !busy_q;
    assign wr_do  = wr_srv && wr_ok;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        remain_d   = remain_q;
        busy_d     = busy_q;
        clr_done_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        err_drop_d = err_drop_q | ((mem_rd_en | mem_wr_en) & busy_q);
        err_oob_d  = err_oob_q;
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;

`ifdef MATRIX_MEM_RANGE_CHECK_EN
        err_oob_d = err_oob_q | (rd_srv & ~rd_ok) | (wr_srv & ~wr_ok);
`endif

        // write-first: a same-edge write to the read address bypasses the array
        if (rd_srv) begin
            if (!rd_ok) begin
                rd_data_d = '0;
            end else if (wr_do && (wr_idx == rd_idx)) begin
                rd_data_d = mem_wr_data;
            end else begin
                rd_data_d = mem[rd_idx[IW-1:0]];
            end
            if (rd_count_q != 16'hFFFF) begin
                rd_count_d = rd_count_q + 16'd1;
            end
        end

        if (wr_srv && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end

        if (wr_do) begin
            mem_we    = 1'b1;
            mem_waddr = wr_idx;
            mem_wdata = mem_wr_data;
        end

        case (state_q)
            S_IDLE: begin
                if (clr_start) begin
`ifdef MATRIX_MEM_RANGE_CHECK_EN
                    ptr_d = clr_base;
`else
                    ptr_d = wrap_addr(clr_base);
`endif
                    remain_d = clr_len;
                    if (clr_len == '0) begin
                        state_d    = S_DONE;
                        clr_done_d = 1'b1;
                    end else begin
                        state_d = S_CLEAR;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (!in_range(ptr_q)) begin
                    // only reachable with range check: pointer hit MEM_DEPTH
                    err_oob_d  = 1'b1;
                    state_d    = S_DONE;
                    busy_d     = 1'b0;
                    clr_done_d = 1'b1;
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr_q;
                    mem_wdata = '0;
`ifdef MATRIX_MEM_RANGE_CHECK_EN
                    ptr_d = ptr_q + 1'b1;
`else
                    ptr_d = ({1'b0, ptr_q} == DEPTH - 1'b1) ? '0
                                                            : ptr_q + 1'b1;
`endif
                    remain_d = remain_q - 1'b1;
                    if (remain_q == (ADDR_WIDTH+1)'(1)) begin
                        state_d    = S_DONE;
                        busy_d     = 1'b0;
                        clr_done_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            remain_q   <= '0;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
            rd_data_q  <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
            err_drop_q <= 1'b0;
            err_oob_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            remain_q   <= remain_d;
            busy_q     <= busy_d;
            clr_done_q <= clr_done_d;
            rd_data_q  <= rd_data_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            err_drop_q <= err_drop_d;
            err_oob_q  <= err_oob_d;
        end
    end

    // storage is never reset; a reset edge suppresses any pending write
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr[IW-1:0]] <= mem_wdata;
        end
    end

    assign mem_rd_data = rd_data_q;
    assign busy        = busy_q;
    assign clr_done    = clr_done_q;
    assign rd_count    = rd_count_q;
    assign wr_count    = wr_count_q;
    assign err_drop    = err_drop_q;
`ifdef MATRIX_MEM_RANGE_CHECK_EN
    assign err_oob     = err_oob_q;
`else
    assign err_oob     = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_mem_responder.sv
// Testbench for matrix_mem_responder: scoreboard of expected read data
// pushed when reads are issued and compared when the data is registered.

module tb_matrix_mem_responder;

    localparam int EW    = 16;
    localparam int AW    = 12;
    localparam int DEPTH = 2048;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [EW-1:0] mem_rd_data;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [EW-1:0] mem_wr_data;
    logic          clr_start;
    logic [AW-1:0] clr_base;
    logic [AW:0]   clr_len;
    logic          busy;
    logic          clr_done;
    logic [15:0]   rd_count;
    logic [15:0]   wr_count;
    logic          err_drop;
    logic          err_oob;

    matrix_mem_responder #(
        .ELEMENT_WIDTH(EW),
        .ADDR_WIDTH   (AW),
        .MEM_DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .clr_start  (clr_start),
        .clr_base   (clr_base),
        .clr_len    (clr_len),
        .busy       (busy),
        .clr_done   (clr_done),
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .err_drop   (err_drop),
        .err_oob    (err_oob)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    int            exp_rd = 0;
    int            exp_wr = 0;
    logic [EW-1:0] last_rd = '0;
    logic [EW-1:0] model [DEPTH];
    logic [EW-1:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] model_rd(input int a);
`ifdef MATRIX_MEM_RANGE_CHECK_EN
        if (a >= DEPTH) return '0;
`endif
        return model[a % DEPTH];
    endfunction

    task automatic model_wr(input int a, input logic [EW-1:0] d);
`ifdef MATRIX_MEM_RANGE_CHECK_EN
        if (a >= DEPTH) return;
`endif
        model[a % DEPTH] = d;
    endtask

    task automatic do_write(input int a, input logic [EW-1:0] d);
        mem_wr_en   = 1'b1;
        mem_wr_addr = AW'(a);
        mem_wr_data = d;
        tick();
        mem_wr_en   = 1'b0;
        model_wr(a, d);
        exp_wr++;
    endtask

    task automatic issue_read(input int a);
        mem_rd_en   = 1'b1;
        mem_rd_addr = AW'(a);
        exp_q.push_back(model_rd(a));
        tick();
        mem_rd_en   = 1'b0;
        exp_rd++;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_rd  = 0;
        exp_wr  = 0;
        last_rd = '0;
    endtask

    task automatic test_reset();
        mem_rd_en = 0; mem_wr_en = 0; clr_start = 0;
        mem_rd_addr = '0; mem_wr_addr = '0; mem_wr_data = '0;
        clr_base = '0; clr_len = '0;
        apply_reset();
        n_cmp++;
        if (mem_rd_data !== 16'h0) begin
            n_err++;
            $display("FAIL reset_rd_data got=%h exp=0000", mem_rd_data);
        end
        n_cmp++;
        if ({busy, clr_done, err_drop, err_oob} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {busy, clr_done, err_drop, err_oob});
        end
        n_cmp++;
        if (rd_count !== 16'h0 || wr_count !== 16'h0) begin
            n_err++;
            $display("FAIL reset_counts got=%h/%h exp=0000/0000",
                     rd_count, wr_count);
        end
    endtask

    task automatic test_write_read();
        logic [EW-1:0] e;
        do_write(3, 16'h00A5);
        issue_read(3);
        e = exp_q.pop_front();
        last_rd = e;
        n_cmp++;
        if (mem_rd_data !== e) begin
            n_err++;
            $display("FAIL wr_rd got=%h exp=%h", mem_rd_data, e);
        end
        tick();
        tick();
        n_cmp++;
        if (mem_rd_data !== last_rd) begin
            n_err++;
            $display("FAIL rd_hold got=%h exp=%h", mem_rd_data, last_rd);
        end
    endtask

    task automatic test_write_first();
        logic [EW-1:0] e;
        apply_reset();
        mem_wr_en   = 1'b1;
        mem_wr_addr = AW'(7);
        mem_wr_data = 16'h1234;
        model_wr(7, 16'h1234);
        exp_wr++;
        issue_read(7);
        mem_wr_en = 1'b0;
        e = exp_q.pop_front();
        last_rd = e;
        n_cmp++;
        if (mem_rd_data !== e) begin
            n_err++;
            $display("FAIL write_first got=%h exp=%h", mem_rd_data, e);
        end
        n_cmp++;
        if (rd_count !== 16'(exp_rd) || wr_count !== 16'(exp_wr)) begin
            n_err++;
            $display("FAIL wf_counts got=%0d/%0d exp=%0d/%0d",
                     rd_count, wr_count, exp_rd, exp_wr);
        end
    endtask

    task automatic test_clear();
        logic [EW-1:0] e;
        int bc;
        bit seen;
        for (int a = 10; a <= 14; a++) do_write(a, 16'hFFFF);
        clr_base  = AW'(11);
        clr_len   = (AW+1)'(3);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        bc = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (clr_done) begin
                seen = 1;
                break;
            end
            if (busy) bc++;
            tick();
        end
        n_cmp++;
        if (!seen || bc != 3) begin
            n_err++;
            $display("FAIL clr_busy_len got=%0d done=%0d exp=3 done=1",
                     bc, seen);
        end
        tick();
        n_cmp++;
        if (clr_done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL clr_done_pulse got=%b%b exp=00", clr_done, busy);
        end
        for (int a = 11; a <= 13; a++) model[a] = '0;
        for (int a = 10; a <= 14; a++) begin
            issue_read(a);
            e = exp_q.pop_front();
            last_rd = e;
            n_cmp++;
            if (mem_rd_data !== e) begin
                n_err++;
                $display("FAIL clr_read a=%0d got=%h exp=%h",
                         a, mem_rd_data, e);
            end
        end
    endtask

    task automatic test_drop();
        logic [EW-1:0] e;
        bit seen;
        do_write(200, 16'h1111);
        clr_base  = AW'(100);
        clr_len   = (AW+1)'(4);
        clr_start = 1'b1;
        tick();
        clr_start   = 1'b0;
        mem_wr_en   = 1'b1;
        mem_wr_addr = AW'(200);
        mem_wr_data = 16'h5555;
        mem_rd_en   = 1'b1;
        mem_rd_addr = AW'(200);
        tick();
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        n_cmp++;
        if (err_drop !== 1'b1) begin
            n_err++;
            $display("FAIL err_drop got=%b exp=1", err_drop);
        end
        n_cmp++;
        if (rd_count !== 16'(exp_rd) || wr_count !== 16'(exp_wr)) begin
            n_err++;
            $display("FAIL drop_counts got=%0d/%0d exp=%0d/%0d",
                     rd_count, wr_count, exp_rd, exp_wr);
        end
        n_cmp++;
        if (mem_rd_data !== last_rd) begin
            n_err++;
            $display("FAIL drop_rd_hold got=%h exp=%h", mem_rd_data, last_rd);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (clr_done) begin
                seen = 1;
                break;
            end
            tick();
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL drop_clr_timeout got=0 exp=1");
        end
        for (int a = 100; a <= 103; a++) model[a] = '0;
        tick();
        issue_read(200);
        e = exp_q.pop_front();
        last_rd = e;
        n_cmp++;
        if (mem_rd_data !== e) begin
            n_err++;
            $display("FAIL drop_array got=%h exp=%h", mem_rd_data, e);
        end
    endtask

    task automatic test_len0();
        clr_base  = AW'(50);
        clr_len   = '0;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        n_cmp++;
        if (clr_done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL len0_done got=%b%b exp=10", clr_done, busy);
        end
        tick();
        n_cmp++;
        if (clr_done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL len0_after got=%b%b exp=00", clr_done, busy);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [EW-1:0] e;
        int dc;
        for (int a = 300; a <= 307; a++) do_write(a, 16'hBEEF);
        clr_base  = AW'(300);
        clr_len   = (AW+1)'(8);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_rd  = 0;
        exp_wr  = 0;
        last_rd = '0;
        n_cmp++;
        if (busy !== 1'b0 || rd_count !== 16'h0 || wr_count !== 16'h0) begin
            n_err++;
            $display("FAIL rst_mid got=%b %0d %0d exp=0 0 0",
                     busy, rd_count, wr_count);
        end
        dc = 0;
        for (int i = 0; i < 12; i++) begin
            if (clr_done) dc++;
            tick();
        end
        n_cmp++;
        if (dc != 0) begin
            n_err++;
            $display("FAIL rst_mid_done got=%0d exp=0", dc);
        end
        for (int a = 300; a <= 303; a++) model[a] = '0;
        for (int a = 300; a <= 307; a++) begin
            issue_read(a);
            e = exp_q.pop_front();
            last_rd = e;
            n_cmp++;
            if (mem_rd_data !== e) begin
                n_err++;
                $display("FAIL rst_mid_read a=%0d got=%h exp=%h",
                         a, mem_rd_data, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] e;
        int t0, t1, np;
        do_write(500, 16'h2222);
        do_write(501, 16'h2222);
        clr_base  = AW'(500);
        clr_len   = (AW+1)'(2);
        clr_start = 1'b1;
        np = 0;
        t0 = 0;
        t1 = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (clr_done) begin
                if (np == 0) t0 = i;
                else t1 = i;
                np++;
                if (np == 2) break;
            end
        end
        clr_start = 1'b0;
        n_cmp++;
        if (np != 2 || (t1 - t0) != 4) begin
            n_err++;
            $display("FAIL b2b_period got=%0d pulses=%0d exp=4 pulses=2",
                     t1 - t0, np);
        end
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_stop got=%b exp=0", busy);
        end
        model[500] = '0;
        model[501] = '0;
        for (int a = 500; a <= 501; a++) begin
            issue_read(a);
            e = exp_q.pop_front();
            last_rd = e;
            n_cmp++;
            if (mem_rd_data !== e) begin
                n_err++;
                $display("FAIL b2b_read a=%0d got=%h exp=%h",
                         a, mem_rd_data, e);
            end
        end
    endtask

    task automatic test_oob();
        logic [EW-1:0] e;
        logic          exp_oob;
        do_write(0, 16'h7777);
        do_write(DEPTH, 16'hABCD);
`ifdef MATRIX_MEM_RANGE_CHECK_EN
        exp_oob = 1'b1;
`else
        exp_oob = 1'b0;
`endif
        n_cmp++;
        if (err_oob !== exp_oob) begin
            n_err++;
            $display("FAIL err_oob got=%b exp=%b", err_oob, exp_oob);
        end
        issue_read(0);
        e = exp_q.pop_front();
        n_cmp++;
        if (mem_rd_data !== e) begin
            n_err++;
            $display("FAIL oob_addr0 got=%h exp=%h", mem_rd_data, e);
        end
        issue_read(DEPTH);
        e = exp_q.pop_front();
        n_cmp++;
        if (mem_rd_data !== e) begin
            n_err++;
            $display("FAIL oob_read got=%h exp=%h", mem_rd_data, e);
        end
        n_cmp++;
        if (rd_count !== 16'(exp_rd) || wr_count !== 16'(exp_wr)) begin
            n_err++;
            $display("FAIL oob_counts got=%0d/%0d exp=%0d/%0d",
                     rd_count, wr_count, exp_rd, exp_wr);
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_write_read();
        test_write_first();
        test_clear();
        test_drop();
        test_len0();
        test_reset_mid_clear();
        test_back_to_back();
        test_oob();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
